// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: header beat then incrementing index beats, with a configurable gap between packets.
// All outputs are registered; one beat per cycle when tready=1, and each beat is held stable while tready=0.
module axis_pkt_gen #(
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
   parameter logic [AXIS_DATA_WIDTH-1:0] HDR_TEMPLATE = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [15:0]                cfg_len_beats,
   input  logic [15:0]                cfg_pkt_count,
   input  logic [7:0]                 cfg_gap,
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic                       busy,
   output logic                       done,
   output logic [15:0]                sent_count
);

   typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;

   state_t                     state_q, state_d;
   logic [15:0]                len_q, len_d;
   logic [15:0]                cnt_q, cnt_d;
   logic [7:0]                 gap_q, gap_d;
   logic [7:0]                 gap_cnt_q, gap_cnt_d;
   logic [15:0]                b_q, b_d;
   logic [15:0]                sent_q, sent_d;
   logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [AXIS_KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
   logic                       tvalid_q, tvalid_d;
   logic                       tlast_q, tlast_d;
   logic                       done_q, done_d;
   logic                       busy_q, busy_d;

   logic [15:0] len_eff;
   logic [15:0] b_nxt;
   logic [15:0] sent_nxt;

   assign len_eff  = (cfg_len_beats == 16'd0) ? 16'd1 : cfg_len_beats;
   assign b_nxt    = b_q + 16'd1;
   assign sent_nxt = sent_q + 16'd1;

   // Beat 0 carries the header with the 16-bit length field at bytes 16/17 (big-endian).
   function automatic logic [AXIS_DATA_WIDTH-1:0] beat_data(input logic [15:0] b,
                                                            input logic [15:0] len);
      logic [15:0]                l;
      logic [AXIS_DATA_WIDTH-1:0] d;
      l = (len << 6) - 16'd14;
      if (b == 16'd0) begin
         d          = HDR_TEMPLATE;
         d[135:128] = l[15:8];
         d[143:136] = l[7:0];
      end else begin
         d = {{(AXIS_DATA_WIDTH-16){1'b0}}, b};
      end
      return d;
   endfunction

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      b_d       = b_q;
      sent_d    = sent_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               len_d  = len_eff;
               cnt_d  = cfg_pkt_count;
               gap_d  = cfg_gap;
               sent_d = 16'd0;
               b_d    = 16'd0;
               if (cfg_pkt_count == 16'd0) begin
                  state_d = FINISH;
               end else begin
                  state_d  = SEND;
                  tvalid_d = 1'b1;
                  tdata_d  = beat_data(16'd0, len_eff);
                  tlast_d  = (len_eff == 16'd1);
               end
            end
         end
         SEND: begin
            if (tvalid_q && m_axis_tready) begin
               if (tlast_q) begin
                  b_d    = 16'd0;
                  sent_d = sent_nxt;
                  if (sent_nxt == cnt_q) begin
                     state_d  = FINISH;
                     tvalid_d = 1'b0;
                     tlast_d  = 1'b0;
                  end else if (gap_q != 8'd0) begin
                     state_d   = GAP;
                     gap_cnt_d = gap_q;
                     tvalid_d  = 1'b0;
                     tlast_d   = 1'b0;
                  end else begin
                     tdata_d = beat_data(16'd0, len_q);
                     tlast_d = (len_q == 16'd1);
                  end
               end else begin
                  b_d     = b_nxt;
                  tdata_d = beat_data(b_nxt, len_q);
                  tlast_d = (b_nxt == len_q - 16'd1);
               end
            end
         end
         GAP: begin
            // The count is loaded on entry, so leaving at 1 yields exactly gap idle cycles.
            if (gap_cnt_q <= 8'd1) begin
               state_d  = SEND;
               tvalid_d = 1'b1;
               tdata_d  = beat_data(16'd0, len_q);
               tlast_d  = (len_q == 16'd1);
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d != IDLE);
      tkeep_d = tvalid_d ? {AXIS_KEEP_WIDTH{1'b1}} : {AXIS_KEEP_WIDTH{1'b0}};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= 16'd0;
         cnt_q     <= 16'd0;
         gap_q     <= 8'd0;
         gap_cnt_q <= 8'd0;
         b_q       <= 16'd0;
         sent_q    <= 16'd0;
         tdata_q   <= '0;
         tkeep_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
         b_q       <= b_d;
         sent_q    <= sent_d;
         tdata_q   <= tdata_d;
         tkeep_q   <= tkeep_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign sent_count    = sent_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: expected beats are queued at start and checked by a negedge monitor.
module tb_axis_pkt_gen;
   localparam int DW = 512;
   localparam int KW = DW/8;
   localparam logic [DW-1:0] HDR = {16{32'hA5C3_0F96}};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   cfg_len_beats = 16'd0;
   logic [15:0]   cfg_pkt_count = 16'd0;
   logic [7:0]    cfg_gap = 8'd0;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;
   logic          busy;
   logic          done;
   logic [15:0]   sent_count;

   axis_pkt_gen #(.AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .HDR_TEMPLATE(HDR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_len_beats(cfg_len_beats), .cfg_pkt_count(cfg_pkt_count), .cfg_gap(cfg_gap),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .busy(busy), .done(done), .sent_count(sent_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   int      tests_run = 0;
   int      fails = 0;
   int      cyc = 0;
   int      done_cnt = 0;
   int      done_cyc = 0;
   beat_t   exp_q[$];
   int      hs_cyc[$];
   bit      stall_pend = 0;
   logic [DW-1:0] stall_d;
   logic    stall_l;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic beat_t mk(input int b, input logic [15:0] len_l, input bit last);
      beat_t e;
      if (b == 0) begin
         e.d          = HDR;
         e.d[135:128] = len_l[15:8];
         e.d[143:136] = len_l[7:0];
      end else begin
         e.d = DW'(b);
      end
      e.l = last;
      return e;
   endfunction

   // Monitor: scoreboard pop on every handshake, and stall stability checks.
   always @(negedge clk) begin : mon
      beat_t e;
      if (!rst_n) begin
         stall_pend = 0;
      end else begin
         if (stall_pend) begin
            tests_run++;
            if (m_axis_tvalid !== 1'b1) begin
               fails++;
               $display("FAIL valid_drop: tvalid=%b required 1 (no handshake yet)", m_axis_tvalid);
            end else if (m_axis_tdata !== stall_d || m_axis_tlast !== stall_l) begin
               fails++;
               $display("FAIL stall_stable: tdata=%h tlast=%b required tdata=%h tlast=%b",
                        m_axis_tdata, m_axis_tlast, stall_d, stall_l);
            end
         end
         stall_pend = 0;
         if (m_axis_tvalid) begin
            tests_run++;
            if (m_axis_tkeep !== {KW{1'b1}}) begin
               fails++;
               $display("FAIL tkeep: got %h required all ones", m_axis_tkeep);
            end
            if (m_axis_tready) begin
               tests_run++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_beat: tdata=%h tlast=%b required no beat", m_axis_tdata, m_axis_tlast);
               end else begin
                  e = exp_q.pop_front();
                  if (m_axis_tdata !== e.d || m_axis_tlast !== e.l) begin
                     fails++;
                     $display("FAIL beat: tdata=%h tlast=%b required tdata=%h tlast=%b",
                              m_axis_tdata, m_axis_tlast, e.d, e.l);
                  end
               end
               hs_cyc.push_back(cyc);
            end else begin
               stall_pend = 1;
               stall_d    = m_axis_tdata;
               stall_l    = m_axis_tlast;
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic push_pkts(input int len, input int cnt, input logic [15:0] len_l);
      for (int p = 0; p < cnt; p++)
         for (int b = 0; b < len; b++)
            exp_q.push_back(mk(b, len_l, b == len - 1));
   endtask

   task automatic kick(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap);
      @(posedge clk); #1;
      cfg_len_beats = len;
      cfg_pkt_count = cnt;
      cfg_gap       = gap;
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: tvalid=%b tlast=%b done=%b busy=%b required all 0",
                  m_axis_tvalid, m_axis_tlast, done, busy);
      end
      tests_run++;
      if (sent_count !== 16'd0 || m_axis_tkeep !== '0 || m_axis_tdata !== '0) begin
         fails++;
         $display("FAIL reset_data: sent=%0d tkeep=%h required 0/0 with tdata 0", sent_count, m_axis_tkeep);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (m_axis_tvalid !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: tvalid=%b required 0", m_axis_tvalid);
      end
   endtask

   task automatic test_back_to_back;
      int h0 = hs_cyc.size();
      int d0 = done_cnt;
      bit ok;
      bit gapless = 1;
      m_axis_tready = 1'b1;
      push_pkts(1, 16, 16'h0032);
      kick(16'd1, 16'd16, 8'd0);
      wait_done(200, ok);
      tests_run++;
      if (!ok) begin fails++; $display("FAIL b2b_timeout: done=0 required 1 within 200 cycles"); end
      tests_run++;
      if (hs_cyc.size() - h0 != 16) begin
         fails++;
         $display("FAIL b2b_beats: got %0d required 16", hs_cyc.size() - h0);
      end else begin
         for (int i = 1; i < 16; i++)
            if (hs_cyc[h0+i] != hs_cyc[h0+i-1] + 1) gapless = 0;
         tests_run++;
         if (!gapless) begin fails++; $display("FAIL b2b_bubbles: bubbles=1 required 0"); end
         tests_run++;
         if (done_cyc - hs_cyc[h0+15] != 2) begin
            fails++;
            $display("FAIL b2b_done_lat: got %0d required 2", done_cyc - hs_cyc[h0+15]);
         end
      end
      tests_run++;
      if (sent_count !== 16'd16) begin fails++; $display("FAIL b2b_sent: got %0d required 16", sent_count); end
      tests_run++;
      if (done_cnt - d0 != 1) begin fails++; $display("FAIL b2b_done_cnt: got %0d required 1", done_cnt - d0); end
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_leftover: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_gap;
      int h0 = hs_cyc.size();
      int d0 = done_cnt;
      bit ok;
      bit shape = 1;
      m_axis_tready = 1'b1;
      push_pkts(4, 2, 16'h00F2);
      kick(16'd4, 16'd2, 8'd3);
      wait_done(200, ok);
      tests_run++;
      if (!ok) begin fails++; $display("FAIL gap_timeout: done=0 required 1 within 200 cycles"); end
      tests_run++;
      if (hs_cyc.size() - h0 != 8) begin
         fails++;
         $display("FAIL gap_beats: got %0d required 8", hs_cyc.size() - h0);
      end else begin
         for (int i = 1; i < 8; i++)
            if (hs_cyc[h0+i] - hs_cyc[h0+i-1] != ((i == 4) ? 4 : 1)) shape = 0;
         tests_run++;
         if (!shape) begin
            fails++;
            $display("FAIL gap_spacing: idle=%0d required 3 and no bubbles", hs_cyc[h0+4] - hs_cyc[h0+3] - 1);
         end
      end
      tests_run++;
      if (sent_count !== 16'd2) begin fails++; $display("FAIL gap_sent: got %0d required 2", sent_count); end
      tests_run++;
      if (done_cnt - d0 != 1) begin fails++; $display("FAIL gap_done_cnt: got %0d required 1", done_cnt - d0); end
   endtask

   task automatic test_stall;
      int h0 = hs_cyc.size();
      int d0 = done_cnt;
      bit ok = 0;
      m_axis_tready = 1'b0;
      push_pkts(3, 1, 16'h00B2);
      kick(16'd3, 16'd1, 8'd0);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         m_axis_tready = 1'($urandom_range(0, 1));
         if (done) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk); #1;
      tests_run++;
      if (!ok) begin fails++; $display("FAIL stall_timeout: done=0 required 1 within 300 cycles"); end
      tests_run++;
      if (hs_cyc.size() - h0 != 3) begin fails++; $display("FAIL stall_hs: got %0d required 3", hs_cyc.size() - h0); end
      tests_run++;
      if (done_cnt - d0 != 1) begin fails++; $display("FAIL stall_done_cnt: got %0d required 1", done_cnt - d0); end
      tests_run++;
      if (sent_count !== 16'd1) begin fails++; $display("FAIL stall_sent: got %0d required 1", sent_count); end
      m_axis_tready = 1'b1;
   endtask

   task automatic test_zero_count;
      int h0 = hs_cyc.size();
      kick(16'd5, 16'd0, 8'd2);
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL zero_c1: tvalid=%b busy=%b done=%b required 0/1/0", m_axis_tvalid, busy, done);
      end
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0 || sent_count !== 16'd0) begin
         fails++;
         $display("FAIL zero_c2: done=%b busy=%b sent=%0d required 1/0/0", done, busy, sent_count);
      end
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0) begin fails++; $display("FAIL zero_c3: done=%b required 0", done); end
      tests_run++;
      if (hs_cyc.size() != h0) begin fails++; $display("FAIL zero_beats: got %0d required 0", hs_cyc.size() - h0); end
   endtask

   task automatic test_mid_reset;
      int d0 = done_cnt;
      int h0;
      bit ok;
      beat_t e2;
      m_axis_tready = 1'b1;
      push_pkts(2, 1, 16'h00F2);
      exp_q[1].l = 1'b0;
      kick(16'd4, 16'd1, 8'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      e2 = mk(2, 16'h00F2, 1'b0);
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== e2.d) begin
         fails++;
         $display("FAIL mr_beat2: tvalid=%b tdata=%h required 1 and beat index 2", m_axis_tvalid, m_axis_tdata);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || sent_count !== 16'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL mr_abandon: tvalid=%b sent=%0d busy=%b required 0/0/0", m_axis_tvalid, sent_count, busy);
      end
      rst_n = 1'b1;
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL mr_beats: pending=%0d required 0", exp_q.size()); end
      exp_q.delete();
      h0 = hs_cyc.size();
      repeat (5) @(posedge clk);
      #1;
      tests_run++;
      if (done_cnt != d0 || hs_cyc.size() != h0) begin
         fails++;
         $display("FAIL mr_quiet: done=%0d beats=%0d required 0/0", done_cnt - d0, hs_cyc.size() - h0);
      end
      push_pkts(4, 1, 16'h00F2);
      kick(16'd4, 16'd1, 8'd0);
      wait_done(100, ok);
      tests_run++;
      if (!ok || sent_count !== 16'd1 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL mr_rerun: done=%b sent=%0d pending=%0d required 1/1/0", ok, sent_count, exp_q.size());
      end
   endtask

   task automatic test_len_zero;
      int h0 = hs_cyc.size();
      int d0 = done_cnt;
      bit ok;
      m_axis_tready = 1'b1;
      push_pkts(1, 2, 16'h0032);
      kick(16'd0, 16'd2, 8'd1);
      @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b1) begin fails++; $display("FAIL lz_busy: got %b required 1", busy); end
      cfg_len_beats = 16'd5;
      cfg_pkt_count = 16'd9;
      cfg_gap       = 8'd0;
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(100, ok);
      tests_run++;
      if (!ok) begin fails++; $display("FAIL lz_timeout: done=0 required 1 within 100 cycles"); end
      tests_run++;
      if (hs_cyc.size() - h0 != 2 || sent_count !== 16'd2) begin
         fails++;
         $display("FAIL lz_count: beats=%0d sent=%0d required 2/2", hs_cyc.size() - h0, sent_count);
      end
      tests_run++;
      if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL lz_done: done=%0d pending=%0d required 1/0", done_cnt - d0, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gap();
      test_stall();
      test_zero_count();
      test_mid_reset();
      test_len_zero();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 512: width of the AXIS data bus in bits.
REQ-002 SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8: byte-enable width.
REQ-003 SHALL have parameter HDR_TEMPLATE, default 512'h0, width AXIS_DATA_WIDTH: Ethernet/IPv4/UDP header image for beat 0.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: a one-cycle request to begin a run.
REQ-007 SHALL have port cfg_len_beats, input, 16: packet length in beats.
REQ-008 SHALL have port cfg_pkt_count, input, 16: number of packets in the run.
REQ-009 SHALL have port cfg_gap, input, 8: idle cycles inserted between packets.
REQ-010 SHALL have port m_axis_tdata, output, AXIS_DATA_WIDTH: packet data.
REQ-011 SHALL have port m_axis_tkeep, output, AXIS_KEEP_WIDTH: byte enables.
REQ-012 SHALL have port m_axis_tvalid, output, 1: beat valid.
REQ-013 SHALL have port m_axis_tready, input, 1: downstream ready.
REQ-014 SHALL have port m_axis_tlast, output, 1: last beat of a packet.
REQ-015 SHALL have port busy, output, 1: a run is in progress.
REQ-016 SHALL have port done, output, 1: a one-cycle pulse at the end of a run.
REQ-017 SHALL have port sent_count, output, 16: packets completed in the current or last run.

Function
REQ-018 SHALL implement FSM states IDLE, SEND, GAP, FINISH.
REQ-019 SHALL, in IDLE with start=1, latch cfg_len_beats, cfg_pkt_count and cfg_gap, clear sent_count, and go to SEND next cycle; when start=1 and the latched cfg_pkt_count=0, SHALL go directly to FINISH.
REQ-020 SHALL treat a latched length of 0 as 1 beat.
REQ-021 SHALL ignore start and cfg_* changes outside IDLE.
REQ-022 SHALL drive m_axis_tvalid=1 only in SEND.
REQ-023 SHALL keep tdata/tkeep/tlast stable while tvalid=1 and tready=0, and SHALL never deassert tvalid without a handshake.
REQ-024 SHALL advance the beat index b (16-bit, 0-based) only on tvalid&&tready.
REQ-025 SHALL drive tkeep all ones on every beat.
REQ-026 SHALL, for beat b=0, drive tdata=HDR_TEMPLATE with byte 16 = L[15:8] and byte 17 = L[7:0], where L=(len_beats*64-14) truncated to 16 bits and byte n is tdata[8n+7:8n].
REQ-027 SHALL, for beats b>0, drive tdata=b zero-extended to AXIS_DATA_WIDTH.
REQ-028 SHALL assert tlast when b=len_beats-1; a 1-beat packet has header and tlast on the same beat.
REQ-029 SHALL, on a tlast handshake, reset b to 0 and increment sent_count.
REQ-030 SHALL then go to FINISH if sent_count+1 equals pkt_count, else to GAP when gap>0, else stay in SEND with the next packet's beat 0 presented on the following cycle.
REQ-031 SHALL hold GAP for exactly gap cycles with tvalid=0, then go to SEND.
REQ-032 SHALL, in FINISH, pulse done=1 for one cycle and return to IDLE.
REQ-033 SHALL keep sent_count valid after a run until the next start.
REQ-034 SHALL drive busy=1 in SEND, GAP and FINISH, and 0 in IDLE.
REQ-035 SHALL generate back-to-back beats with no bubbles when tready is held at 1 (throughput one beat per cycle).

Reset
REQ-036 SHALL, with rst_n=0 at a clock edge, set state=IDLE, b=0, sent_count=0, tvalid=0, tlast=0, done=0, busy=0, tdata=0 and tkeep=0.
REQ-037 SHALL, on a reset mid-packet, abandon the packet immediately with no tlast emitted and no done pulse.
REQ-038 SHALL keep tvalid=0 on the first cycle after rst_n rises.

Verification
REQ-039 SHALL cover: len=1, count=16, gap=0, tready=1 -> 16 consecutive beats, each with tlast=1 and bytes 16/17 = 0x00/0x32, then done after the 16th beat, sent_count=16.
REQ-040 SHALL cover: len=4, count=2, gap=3 -> beats hdr,1,2,3(tlast), 3 idle cycles, hdr,1,2,3(tlast); L=0x00F2.
REQ-041 SHALL cover: len=3, count=1, random tready -> tdata/tlast stable during every stall, exactly 3 handshakes, one done pulse.
REQ-042 SHALL cover: start with count=0 -> no tvalid, done 2 cycles after start, sent_count=0.
REQ-043 SHALL cover: rst_n low on beat 2 of a 4-beat packet -> tvalid=0 next cycle, sent_count=0, no done; a new run then completes normally.
REQ-044 SHALL cover: len=0 -> treated as 1 beat with L=0x0032; start pulsed while busy -> ignored.
